// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared types and constants for the WS2812 one-wire LED driver.
//   - ws2812_state_e : frame sequencer states (IDLE, SEND, LATCH)
//   - DEF_*          : default timing in clk cycles (10 MHz clock)
//   - frame_bits()   : bits per colour frame (three channels)
//   - max_int()      : larger of two integers, used to size the shared counter
package ws2812_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } ws2812_state_e;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_BIT_CYCLES   = 12;
    localparam int DEF_T0H_CYCLES   = 4;
    localparam int DEF_T1H_CYCLES   = 8;
    localparam int DEF_RESET_CYCLES = 600;

    function automatic int frame_bits(input int width);
        return 3 * width;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812_if.sv
// ws2812_if: colour/handshake bundle between the RGB mixer side and the
// WS2812 driver.
//   red/green/blue : channel levels, sampled when a frame is accepted
//   start          : level-sensitive frame request
//   data_out       : serial NRZ line to the LED
//   busy           : frame or latch gap in progress
//   done           : one-cycle pulse at the end of the latch gap
// Modports: master (colour source), slave (driver).
interface ws2812_if
    import ws2812_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic [WIDTH-1:0] red;
    logic [WIDTH-1:0] green;
    logic [WIDTH-1:0] blue;
    logic             start;
    logic             data_out;
    logic             busy;
    logic             done;

    modport master (
        output red, green, blue, start,
        input  data_out, busy, done
    );

    modport slave (
        input  red, green, blue, start,
        output data_out, busy, done
    );

endinterface

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: shared cycle counter for the bit period and the latch gap.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : count this cycle
//   restart     : force the count back to zero (frame start)
//   term        : terminal count; the counter wraps to zero after it
//   hi_cycles   : high time of the bit that will be current next cycle
//   wrap        : combinational strobe, counter is at term while running
//   hi_next     : next-cycle count is below hi_cycles (feeds the
//                 registered serial output so it lines up with the count)
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int CW = $clog2(max_int(DEF_BIT_CYCLES, DEF_RESET_CYCLES))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          restart,
    input  logic [CW-1:0] term,
    input  logic [CW-1:0] hi_cycles,
    output logic          wrap,
    output logic          hi_next
);

    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;

    assign wrap = run && (cyc_q == term);

    always_comb begin
        cyc_d = cyc_q;
        if (restart) begin
            cyc_d = '0;
        end else if (run) begin
            cyc_d = wrap ? '0 : cyc_q + CW'(1);
        end
    end

    assign hi_next = (cyc_d < hi_cycles);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

endmodule

// File: rtl/ws2812_driver.sv
// ws2812_driver: serialises one {green, red, blue} colour frame, MSB first,
// onto a WS2812-style one-wire NRZ line, then holds the line low for the
// latch gap.
//   clk   : system clock
//   reset : asynchronous active-low reset (truncates a frame, no done pulse)
//   bus   : ws2812_if.slave (colour levels, start, data_out, busy, done)
// Optional build macro WS2812_AUTO_REFRESH_EN: after each latch gap the
// colours are re-sampled and the next frame starts without a start request.
//
// state | meaning
// IDLE  | line low, waiting for start
// SEND  | shifting frame bits out, one bit per BIT_CYCLES
// LATCH | line low for RESET_CYCLES so the LED latches the colour
module ws2812_driver
    import ws2812_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic     clk,
    input  logic     reset,
    ws2812_if.slave  bus
);

    localparam int FRAME = frame_bits(WIDTH);
    localparam int CW    = $clog2(max_int(BIT_CYCLES, RESET_CYCLES));
    localparam int BW    = $clog2(FRAME);

    localparam logic [CW-1:0] BIT_TERM   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RESET_TERM = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] T0H_C      = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_C      = CW'(T1H_CYCLES);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME - 1);

    if (!((T0H_CYCLES > 0) && (T0H_CYCLES < T1H_CYCLES) &&
          (T1H_CYCLES < BIT_CYCLES) && (RESET_CYCLES > 0))) begin : g_bad_timing
        $fatal(1, "ws2812_driver: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES and RESET_CYCLES > 0");
    end

    ws2812_state_e    state_q, state_d;
    logic [FRAME-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             data_out_q, data_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             t_run;
    logic             t_restart;
    logic [CW-1:0]    t_term;
    logic [CW-1:0]    t_hi;
    logic             t_wrap;
    logic             t_hi_next;
    logic [FRAME-1:0] frame_load;

    assign frame_load = {bus.green, bus.red, bus.blue};

    // Timer controls depend only on the current state so the wrap strobe
    // never loops back through the next-state logic.
    assign t_run     = (state_q == SEND) || (state_q == LATCH);
    assign t_restart = (state_q == IDLE) && bus.start;
    assign t_term    = (state_q == LATCH) ? RESET_TERM : BIT_TERM;
    // High time is chosen from the bit that will be current after this edge.
    assign t_hi      = shift_d[FRAME-1] ? T1H_C : T0H_C;

    ws2812_bit_timer #(
        .CW (CW)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (reset),
        .run       (t_run),
        .restart   (t_restart),
        .term      (t_term),
        .hi_cycles (t_hi),
        .wrap      (t_wrap),
        .hi_next   (t_hi_next)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d   = SEND;
                    shift_d   = frame_load;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end

            SEND: begin
                if (t_wrap) begin
                    shift_d   = {shift_q[FRAME-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = LATCH;
                        bit_idx_d = '0;
                    end
                end
            end

            LATCH: begin
                if (t_wrap) begin
                    done_d = 1'b1;
`ifdef WS2812_AUTO_REFRESH_EN
                    state_d   = SEND;
                    shift_d   = frame_load;
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
`else
                    state_d   = IDLE;
                    busy_d    = 1'b0;
`endif
                end
            end

            default: begin
                state_d   = IDLE;
                shift_d   = '0;
                bit_idx_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // The line is only ever high while sending, during the high part of a bit.
    always_comb begin
        data_out_d = 1'b0;
        if (state_d == SEND) begin
            data_out_d = t_hi_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            data_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// tb_ws2812_driver: directed and randomized frames for ws2812_driver,
// compared cycle by cycle against an arithmetic model of the NRZ waveform.
module tb_ws2812_driver;

    localparam int BITC      = 12;
    localparam int T0H       = 4;
    localparam int T1H       = 8;
    localparam int RSTC      = 600;
    localparam int SEND_CYC  = 24 * BITC;
    localparam int BUSY_CYC  = SEND_CYC + RSTC;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    ws2812_if #(.WIDTH(8)) bus ();

    ws2812_driver #(
        .WIDTH        (8),
        .BIT_CYCLES   (BITC),
        .T0H_CYCLES   (T0H),
        .T1H_CYCLES   (T1H),
        .RESET_CYCLES (RSTC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Expected line level t cycles after the accepting edge.
    function automatic logic model_dout(input logic [23:0] fr, input int t);
        int  bit_no;
        int  phase;
        logic b;
        if (t >= SEND_CYC) return 1'b0;
        bit_no = t / BITC;
        phase  = t % BITC;
        b      = fr[23 - bit_no];
        return (phase < (b ? T1H : T0H));
    endfunction

    task automatic check_all(input string what, input int t, input logic ed, input logic eb, input logic en);
        check($sformatf("%s data_out t=%0d", what, t), bus.data_out, ed);
        check($sformatf("%s busy t=%0d", what, t), bus.busy, eb);
        check($sformatf("%s done t=%0d", what, t), bus.done, en);
    endtask

    // poke_kind: 0 none, 1 one-cycle start pulse, 2 red -> FF, 3 all colours random
    task automatic run_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                             input bit hold, input int poke_t, input int poke_kind);
        logic [23:0] fr;
        int          last_t;
        bus.green = g;
        bus.red   = r;
        bus.blue  = b;
        bus.start = 1'b1;
        fr        = {g, r, b};
        last_t    = hold ? BUSY_CYC : BUSY_CYC + 1;
        @(posedge clk);
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            check_all("frame", t, model_dout(fr, t), (t < BUSY_CYC), (t == BUSY_CYC));
            if (!hold) bus.start = (t == poke_t) && (poke_kind == 1);
            if (t == poke_t && poke_kind == 2) bus.red = 8'hFF;
            if (t == poke_t && poke_kind == 3) begin
                bus.green = 8'($urandom);
                bus.red   = 8'($urandom);
                bus.blue  = 8'($urandom);
            end
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_all("idle", i, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [23:0] fr;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.green   = 8'h00;
        bus.red     = 8'h00;
        bus.blue    = 8'h00;

        repeat (3) @(negedge clk);
        check_all("reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle_check(3);

        // Directed frame: G all ones, R all zeros, B alternating.
        run_frame(8'hFF, 8'h00, 8'hAA, 1'b0, -1, 0);
        idle_check(5);

        // start held high: next frame accepted in the done cycle.
        run_frame(8'h5A, 8'hC3, 8'h0F, 1'b1, -1, 0);
        run_frame(8'h81, 8'h7E, 8'h33, 1'b0, -1, 0);
        idle_check(3);

        // start pulses during SEND and during LATCH are ignored.
        run_frame(8'h12, 8'h34, 8'h56, 1'b0, 100, 1);
        run_frame(8'hA5, 8'h5A, 8'hF0, 1'b0, 500, 1);
        idle_check(20);

        // red changed mid-frame does not affect the frame in flight.
        run_frame(8'h3C, 8'h00, 8'hC3, 1'b0, 50, 2);
        idle_check(3);

        // Reset during bit 10.
        bus.green = 8'hF0;
        bus.red   = 8'h0F;
        bus.blue  = 8'h99;
        bus.start = 1'b1;
        fr        = {8'hF0, 8'h0F, 8'h99};
        @(posedge clk);
        for (int t = 0; t < 10 * BITC + 3; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check($sformatf("pre-reset data_out t=%0d", t), bus.data_out, model_dout(fr, t));
        end
        #2 reset = 1'b0;
        #1;
        check_all("midreset", 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_all("midreset", 2, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        idle_check(1000);

        run_frame(8'hE7, 8'h18, 8'h66, 1'b0, -1, 0);
        idle_check(3);

        // Randomized frames with random interference.
        for (int n = 0; n < 5; n++) begin
            run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                      int'($urandom_range(0, BUSY_CYC - 2)), int'($urandom_range(0, 3)));
            idle_check(int'($urandom_range(1, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ws2812_driver.md
Name: ws2812_driver

Overview:
Downstream consumer of the three 8-bit channel levels produced by the encoders in the RGB mixer. It serialises one colour frame to a single WS2812-style addressable LED over a one-wire NRZ line. The block sits alongside the per-channel PWM outputs and drives the same colour to a smart LED. It captures the levels on a start request, shifts them out in G,R,B order MSB-first, then holds the line low for the latch gap.

Parameters:
WIDTH, 8, bits per colour channel; frame length is 3*WIDTH bits
BIT_CYCLES, 12, clk cycles per bit period (1.2 us at 10 MHz)
T0H_CYCLES, 4, high time of a '0' bit in clk cycles
T1H_CYCLES, 8, high time of a '1' bit in clk cycles
RESET_CYCLES, 600, low time of the latch gap after a frame (60 us at 10 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
red  input  WIDTH  red level, sampled on start acceptance
green  input  WIDTH  green level, sampled on start acceptance
blue  input  WIDTH  blue level, sampled on start acceptance
start  input  1  frame request, level-sensitive, only accepted in IDLE
data_out  output  1  serial line to LED, registered
busy  output  1  high while a frame or latch gap is in progress
done  output  1  one-cycle pulse when the latch gap completes

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, data_out=0, busy=0, done=0, all counters and shift register 0. Reset mid-frame truncates the frame immediately, with no completion pulse.
- States: IDLE -> SEND -> LATCH -> IDLE.
- IDLE: data_out=0, busy=0. When start=1 at edge k, load shift register {green,red,blue}, bit_idx=0, cyc=0, and enter SEND. busy=1 and data_out=1 from edge k onward. Latency from start to the first high output is one cycle.
- SEND: each bit lasts exactly BIT_CYCLES cycles.
  - data_out=1 while cyc < (current bit ? T1H_CYCLES : T0H_CYCLES); otherwise 0.
  - cyc wraps at BIT_CYCLES-1. On wrap, shift left by one and increment bit_idx.
  - After bit 3*WIDTH-1 wraps, go to LATCH with cyc=0 and data_out=0.
  - SEND duration is exactly 3*WIDTH*BIT_CYCLES cycles (288 with defaults).
- LATCH: data_out=0 for RESET_CYCLES cycles. When cyc reaches RESET_CYCLES-1, go to IDLE. done=1 and busy=0 on that edge; done returns to 0 one cycle later.
- start while busy=1 is ignored (not queued). start held high continuously re-triggers a new frame in the first IDLE cycle, the same cycle in which done=1.
- Colour inputs that change during a frame do not affect the frame in flight.
- Counter width is $clog2(max(BIT_CYCLES,RESET_CYCLES)). bit_idx width is $clog2(3*WIDTH).
- Elaboration check: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; otherwise a fatal error.

Optional Feature:
WS2812_AUTO_REFRESH_EN
- Defined: after LATCH, the block re-samples red/green/blue and enters SEND directly without start, so it refreshes continuously. done still pulses once per frame. The first frame after reset still requires start.
- Undefined: behaviour is as above, with one frame per accepted start.

Decomposition:
- Shared package ws2812_pkg holds: the state enum (IDLE, SEND, LATCH), the default timing constants, and the FRAME_BITS = 3*WIDTH helper function.
- One natural sub-module, ws2812_bit_timer: the cycle counter with a wrap strobe and the high/low compare for the current bit, reused for both the bit period and the latch gap.

Test Plan:
- Reset, then pulse start for one cycle with green=8'hFF, red=8'h00, blue=8'hAA -> 24 bits observed. Bits 0-7 each high for 8 cycles and low for 4. Bits 8-15 each high for 4 and low for 8. Bits 16-23 alternate 1,0,1,0,... busy=1 for 888 cycles, then done pulses once.
- Hold start=1 through a whole frame -> a second frame begins in the same cycle as done=1, with no extra idle cycle.
- Pulse start again during SEND and during LATCH -> ignored; exactly one frame and one done pulse.
- Change red mid-frame from 8'h00 to 8'hFF -> the transmitted red byte remains 8'h00.
- Assert reset at bit 10 of SEND -> data_out=0 and busy=0 immediately, done never pulses. A subsequent start yields a complete, correct frame.
- With WS2812_AUTO_REFRESH_EN: one start, then no further starts -> frames repeat every 888 cycles with one done pulse each, and a colour change appears in the next frame.
